// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared register-file defines, types and helpers
// for the write-back arbiter slice.
`ifndef RF_WB_DEFINES
`define RF_WB_DEFINES
`define GPR_NUM 32
`define GPR_WIDTH 32
`define GPR_ADDR_SPACE 5
`define RF_STARVE_MAX 3
`endif

package rf_wb_arbiter_pkg;

  localparam int GPR_NUM   = `GPR_NUM;
  localparam int GPR_WIDTH = `GPR_WIDTH;
  localparam int GPR_AW    = `GPR_ADDR_SPACE;

  typedef logic [GPR_AW-1:0]    gpr_addr_t;
  typedef logic [GPR_WIDTH-1:0] gpr_data_t;
  typedef logic [GPR_NUM-1:0]   gpr_mask_t;

  // x0 is hardwired zero, so it never maps to a mask bit
  function automatic gpr_mask_t addr_onehot(input gpr_addr_t a);
    gpr_mask_t v;
    v    = '0;
    v[a] = (a != '0);
    return v;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write bits for long-latency destinations,
// with set-over-clear priority and three combinational read ports.
import rf_wb_arbiter_pkg::*;

module rf_scoreboard (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set_en,
  input  logic [GPR_AW-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [GPR_AW-1:0] i_clr_addr,
  input  logic [GPR_AW-1:0] i_rs1_addr,
  input  logic [GPR_AW-1:0] i_rs2_addr,
  input  logic [GPR_AW-1:0] i_rd_addr,
  output logic              o_rs1_pend,
  output logic              o_rs2_pend,
  output logic              o_rd_pend,
  output logic              o_full
);

  gpr_mask_t r_pend;
  gpr_mask_t w_set_mask;
  gpr_mask_t w_clr_mask;
  gpr_mask_t w_pend_nxt;

  always_comb begin
    w_set_mask = i_set_en ? addr_onehot(i_set_addr) : '0;
    w_clr_mask = i_clr_en ? addr_onehot(i_clr_addr) : '0;
    // a new issue to the same register outranks the returning write
    w_pend_nxt = (r_pend & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  assign o_rs1_pend = r_pend[i_rs1_addr];
  assign o_rs2_pend = r_pend[i_rs2_addr];
  assign o_rd_pend  = r_pend[i_rd_addr];
  assign o_full     = &r_pend[GPR_NUM-1:1];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - single regfile write port shared by the pipeline WB
// path (A, priority) and the long-latency unit (B, starvation-bounded).
import rf_wb_arbiter_pkg::*;

module rf_wb_arbiter #(
  parameter int STARVE_MAX = `RF_STARVE_MAX
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iss_valid_i,
  input  logic                 iss_long_i,
  input  logic [GPR_AW-1:0]    iss_rs1_addr_i,
  input  logic [GPR_AW-1:0]    iss_rs2_addr_i,
  input  logic [GPR_AW-1:0]    iss_rd_addr_i,
  output logic                 stall_o,
  input  logic                 a_valid_i,
  input  logic [GPR_AW-1:0]    a_rd_addr_i,
  input  logic [GPR_WIDTH-1:0] a_rd_val_i,
  output logic                 a_ready_o,
  input  logic                 b_valid_i,
  input  logic [GPR_AW-1:0]    b_rd_addr_i,
  input  logic [GPR_WIDTH-1:0] b_rd_val_i,
  output logic                 b_ready_o,
  output logic                 rd_we_o,
  output logic [GPR_AW-1:0]    rd_addr_o,
  output logic [GPR_WIDTH-1:0] rd_val_o
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0]    r_starve_cnt;
  logic             r_rd_we;
  gpr_addr_t        r_rd_addr;
  gpr_data_t        r_rd_val;

  logic             w_b_force;
  logic             w_a_grant;
  logic             w_b_grant;
  logic             w_rs1_pend;
  logic             w_rs2_pend;
  logic             w_rd_pend;
  logic             w_full;
  logic             w_stall;
  logic             w_set_en;

  // grants double as readys; gating on valid keeps them mutually exclusive
  always_comb begin
    w_b_force = b_valid_i && (r_starve_cnt == STARVE_LIM);
    w_a_grant = !rst_i && a_valid_i && !w_b_force;
    w_b_grant = !rst_i && b_valid_i && !w_a_grant;
  end

  assign a_ready_o = w_a_grant;
  assign b_ready_o = w_b_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (!b_valid_i || w_b_grant) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_LIM) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_val  <= '0;
    end else if (w_a_grant) begin
      r_rd_we   <= (a_rd_addr_i != '0);
      r_rd_addr <= a_rd_addr_i;
      r_rd_val  <= a_rd_val_i;
    end else if (w_b_grant) begin
      r_rd_we   <= (b_rd_addr_i != '0);
      r_rd_addr <= b_rd_addr_i;
      r_rd_val  <= b_rd_val_i;
    end else begin
      r_rd_we   <= 1'b0;
    end
  end

  assign rd_we_o   = r_rd_we;
  assign rd_addr_o = r_rd_addr;
  assign rd_val_o  = r_rd_val;

  always_comb begin
    w_stall  = iss_valid_i &&
               (w_rs1_pend || w_rs2_pend || w_rd_pend || (iss_long_i && w_full));
    w_set_en = iss_valid_i && iss_long_i && !w_stall && (iss_rd_addr_i != '0);
  end

  assign stall_o = w_stall;

  rf_scoreboard u_scoreboard (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_set_en   (w_set_en),
    .i_set_addr (iss_rd_addr_i),
    .i_clr_en   (w_b_grant),
    .i_clr_addr (b_rd_addr_i),
    .i_rs1_addr (iss_rs1_addr_i),
    .i_rs2_addr (iss_rs2_addr_i),
    .i_rd_addr  (iss_rd_addr_i),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend),
    .o_rd_pend  (w_rd_pend),
    .o_full     (w_full)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter.
import rf_wb_arbiter_pkg::*;

module tb_rf_wb_arbiter;

  logic            clk;
  logic            rst_i;
  logic            iss_valid_i;
  logic            iss_long_i;
  gpr_addr_t       iss_rs1_addr_i;
  gpr_addr_t       iss_rs2_addr_i;
  gpr_addr_t       iss_rd_addr_i;
  logic            stall_o;
  logic            a_valid_i;
  gpr_addr_t       a_rd_addr_i;
  gpr_data_t       a_rd_val_i;
  logic            a_ready_o;
  logic            b_valid_i;
  gpr_addr_t       b_rd_addr_i;
  gpr_data_t       b_rd_val_i;
  logic            b_ready_o;
  logic            rd_we_o;
  gpr_addr_t       rd_addr_o;
  gpr_data_t       rd_val_o;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_arbiter #(.STARVE_MAX(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .iss_valid_i    (iss_valid_i),
    .iss_long_i     (iss_long_i),
    .iss_rs1_addr_i (iss_rs1_addr_i),
    .iss_rs2_addr_i (iss_rs2_addr_i),
    .iss_rd_addr_i  (iss_rd_addr_i),
    .stall_o        (stall_o),
    .a_valid_i      (a_valid_i),
    .a_rd_addr_i    (a_rd_addr_i),
    .a_rd_val_i     (a_rd_val_i),
    .a_ready_o      (a_ready_o),
    .b_valid_i      (b_valid_i),
    .b_rd_addr_i    (b_rd_addr_i),
    .b_rd_val_i     (b_rd_val_i),
    .b_ready_o      (b_ready_o),
    .rd_we_o        (rd_we_o),
    .rd_addr_o      (rd_addr_o),
    .rd_val_o       (rd_val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    a_valid_i = 1'b1; a_rd_addr_i = 5'd3; a_rd_val_i = 32'h1111_1111;
    b_valid_i = 1'b1; b_rd_addr_i = 5'd4; b_rd_val_i = 32'h2222_2222;
    #1;
    n_tests++;
    if (a_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %0b want 0", a_ready_o); end
    n_tests++;
    if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %0b want 0", b_ready_o); end
    step();
    step();
    n_tests++;
    if (rd_we_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_val_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: got we=%0b addr=%0d val=%0h want 0/0/0", rd_we_o, rd_addr_o, rd_val_o);
    end
    n_tests++;
    if (dut.u_scoreboard.r_pend !== 32'd0 || dut.r_starve_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got pend=%0h cnt=%0d want 0/0", dut.u_scoreboard.r_pend, dut.r_starve_cnt);
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_a_write();
    a_valid_i = 1'b1; a_rd_addr_i = 5'd5; a_rd_val_i = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL a_write_ready: got a=%0b b=%0b want 1/0", a_ready_o, b_ready_o);
    end
    step();
    a_valid_i = 1'b0; a_rd_val_i = 32'h0;
    n_tests++;
    if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_val_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL a_write_out: got we=%0b addr=%0d val=%0h want 1/5/deadbeef", rd_we_o, rd_addr_o, rd_val_o);
    end
    step();
    n_tests++;
    if (rd_we_o !== 1'b0 || rd_addr_o !== 5'd5 || rd_val_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL idle_hold: got we=%0b addr=%0d val=%0h want 0/5/deadbeef", rd_we_o, rd_addr_o, rd_val_o);
    end
  endtask

  task automatic test_starvation();
    int exp_a_win [5] = '{1, 1, 1, 0, 1};
    int exp_cnt   [5] = '{0, 1, 2, 3, 0};
    a_valid_i = 1'b1; a_rd_addr_i = 5'd1; a_rd_val_i = 32'hAAAA_0001;
    b_valid_i = 1'b1; b_rd_addr_i = 5'd2; b_rd_val_i = 32'hBBBB_0002;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (a_ready_o !== (exp_a_win[i] == 1) || b_ready_o !== (exp_a_win[i] == 0)) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got a=%0b b=%0b want a=%0d", i, a_ready_o, b_ready_o, exp_a_win[i]);
      end
      n_tests++;
      if (int'(dut.r_starve_cnt) !== exp_cnt[i]) begin
        n_fail++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, dut.r_starve_cnt, exp_cnt[i]);
      end
      step();
      n_tests++;
      if (rd_we_o !== 1'b1 || rd_addr_o !== ((exp_a_win[i] == 1) ? 5'd1 : 5'd2)) begin
        n_fail++; $display("FAIL starve_out[%0d]: got we=%0b addr=%0d want a_win=%0d", i, rd_we_o, rd_addr_o, exp_a_win[i]);
      end
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    step();
  endtask

  task automatic test_raw_stall();
    iss_valid_i = 1'b1; iss_long_i = 1'b1;
    iss_rs1_addr_i = 5'd0; iss_rs2_addr_i = 5'd0; iss_rd_addr_i = 5'd7;
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL long_issue_stall: got %0b want 0", stall_o); end
    step();
    iss_long_i = 1'b0; iss_rs1_addr_i = 5'd7; iss_rd_addr_i = 5'd1;
    #1;
    n_tests++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall_0: got %0b want 1", stall_o); end
    step();
    b_valid_i = 1'b1; b_rd_addr_i = 5'd7; b_rd_val_i = 32'h0000_0777;
    #1;
    n_tests++;
    if (stall_o !== 1'b1 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL raw_stall_1: got stall=%0b b_ready=%0b want 1/1", stall_o, b_ready_o);
    end
    step();
    b_valid_i = 1'b0;
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_release: got %0b want 0", stall_o); end
    n_tests++;
    if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd7 || rd_val_o !== 32'h0000_0777) begin
      n_fail++; $display("FAIL b_write_out: got we=%0b addr=%0d val=%0h want 1/7/777", rd_we_o, rd_addr_o, rd_val_o);
    end
    step();
    iss_valid_i = 1'b0; iss_rs1_addr_i = 5'd0; iss_rd_addr_i = 5'd0;
  endtask

  task automatic test_set_clear_same();
    iss_valid_i = 1'b1; iss_long_i = 1'b1; iss_rd_addr_i = 5'd9;
    b_valid_i = 1'b1; b_rd_addr_i = 5'd9; b_rd_val_i = 32'h9;
    #1;
    n_tests++;
    if (stall_o !== 1'b0 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_hs: got stall=%0b b_ready=%0b want 0/1", stall_o, b_ready_o);
    end
    step();
    iss_valid_i = 1'b0; iss_long_i = 1'b0; iss_rd_addr_i = 5'd0;
    n_tests++;
    if (dut.u_scoreboard.r_pend[9] !== 1'b1) begin
      n_fail++; $display("FAIL set_wins: got bit9=%0b want 1", dut.u_scoreboard.r_pend[9]);
    end
    step();
    b_valid_i = 1'b0;
    n_tests++;
    if (dut.u_scoreboard.r_pend[9] !== 1'b0) begin
      n_fail++; $display("FAIL clear_bit9: got %0b want 0", dut.u_scoreboard.r_pend[9]);
    end
  endtask

  task automatic test_x0();
    b_valid_i = 1'b1; b_rd_addr_i = 5'd0; b_rd_val_i = 32'h1234;
    iss_valid_i = 1'b1; iss_long_i = 1'b1; iss_rd_addr_i = 5'd0;
    #1;
    n_tests++;
    if (b_ready_o !== 1'b1 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_handshake: got b_ready=%0b stall=%0b want 1/0", b_ready_o, stall_o);
    end
    step();
    b_valid_i = 1'b0; iss_valid_i = 1'b0; iss_long_i = 1'b0;
    n_tests++;
    if (rd_we_o !== 1'b0 || dut.u_scoreboard.r_pend !== 32'd0) begin
      n_fail++; $display("FAIL x0_write: got we=%0b pend=%0h want 0/0", rd_we_o, dut.u_scoreboard.r_pend);
    end
  endtask

  task automatic test_full();
    iss_valid_i = 1'b1; iss_long_i = 1'b1;
    iss_rs1_addr_i = 5'd0; iss_rs2_addr_i = 5'd0;
    for (int r = 1; r < 32; r++) begin
      iss_rd_addr_i = 5'(r);
      step();
    end
    iss_rd_addr_i = 5'd0;
    #1;
    n_tests++;
    if (dut.u_scoreboard.r_pend !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL full_vector: got %0h want fffffffe", dut.u_scoreboard.r_pend);
    end
    n_tests++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL full_long_stall: got %0b want 1", stall_o); end
    iss_long_i = 1'b0;
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL full_short_nostall: got %0b want 0", stall_o); end
    iss_valid_i = 1'b0;
  endtask

  task automatic test_reset_busy();
    a_valid_i = 1'b1; a_rd_addr_i = 5'd5; a_rd_val_i = 32'h55;
    step();
    a_valid_i = 1'b0;
    b_valid_i = 1'b1; b_rd_addr_i = 5'd3; b_rd_val_i = 32'h33;
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (dut.u_scoreboard.r_pend[4:3] !== 2'b11) begin
      n_fail++; $display("FAIL busy_pre_bits: got %0b want 11", dut.u_scoreboard.r_pend[4:3]);
    end
    n_tests++;
    if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset_ready: got a=%0b b=%0b want 0/0", a_ready_o, b_ready_o);
    end
    step();
    n_tests++;
    if (dut.u_scoreboard.r_pend !== 32'd0 || rd_we_o !== 1'b0) begin
      n_fail++; $display("FAIL busy_reset_state: got pend=%0h we=%0b want 0/0", dut.u_scoreboard.r_pend, rd_we_o);
    end
    rst_i = 1'b0;
    b_valid_i = 1'b0;
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    iss_valid_i = 1'b0; iss_long_i = 1'b0;
    iss_rs1_addr_i = '0; iss_rs2_addr_i = '0; iss_rd_addr_i = '0;
    a_valid_i = 1'b0; a_rd_addr_i = '0; a_rd_val_i = '0;
    b_valid_i = 1'b0; b_rd_addr_i = '0; b_rd_val_i = '0;
    test_reset();
    test_a_write();
    test_starvation();
    test_raw_stall();
    test_set_clear_same();
    test_x0();
    test_full();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 3, giving the maximum consecutive cycles requester B may lose arbitration before it is forced to win.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports iss_valid_i, input, 1, and iss_long_i, input, 1: the ID stage is issuing an instruction, and that instruction is routed to the long-latency unit.
REQ-005 The block SHALL have ports iss_rs1_addr_i, iss_rs2_addr_i and iss_rd_addr_i, input, `GPR_ADDR_SPACE each: the source and destination register addresses of the issuing instruction.
REQ-006 The block SHALL have port stall_o, output, 1, combinational: issue is blocked this cycle.
REQ-007 The block SHALL have ports a_valid_i, input, 1; a_rd_addr_i, input, `GPR_ADDR_SPACE; a_rd_val_i, input, `GPR_WIDTH; and a_ready_o, output, 1: the pipeline WB write request (requester A).
REQ-008 The block SHALL have ports b_valid_i, input, 1; b_rd_addr_i, input, `GPR_ADDR_SPACE; b_rd_val_i, input, `GPR_WIDTH; and b_ready_o, output, 1: the long-latency unit write request (requester B).
REQ-009 The block SHALL have ports rd_we_o, input-side name for the regfile write port, output, 1; rd_addr_o, output, `GPR_ADDR_SPACE; and rd_val_o, output, `GPR_WIDTH, all registered: the single regfile write port.

Function
REQ-010 A request SHALL complete on the cycle its valid and ready are both high; a valid request SHALL hold its address and data stable until it completes.
REQ-011 a_ready_o and b_ready_o SHALL be combinational and SHALL never both be high.
REQ-012 Arbitration SHALL give A priority, except that B SHALL win when starve_cnt equals STARVE_MAX.
REQ-013 starve_cnt SHALL increment, saturating at STARVE_MAX, each cycle B is valid and loses; it SHALL clear whenever B completes or B is not valid.
REQ-014 A granted request SHALL appear on rd_addr_o and rd_val_o, with rd_we_o high, exactly one cycle after it completes.
REQ-015 A granted request to address 0 SHALL complete its handshake but SHALL produce rd_we_o=0 on the following cycle.
REQ-016 With no grant in a cycle, rd_we_o SHALL be 0 on the next cycle, and rd_addr_o and rd_val_o SHALL hold their previous values.
REQ-017 A scoreboard of `GPR_NUM pending bits SHALL set bit rd on an accepted long issue: iss_valid_i, iss_long_i, stall_o=0 and rd≠0.
REQ-018 The scoreboard SHALL clear bit b_rd_addr_i on the cycle B completes.
REQ-019 If a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-020 stall_o SHALL be high when iss_valid_i is high and the pending bit of rs1, rs2 or rd (RAW/WAW) is set; bit 0 SHALL never read as pending.
REQ-021 stall_o SHALL also be high on a long issue while all `GPR_NUM-1 pending bits are set.
REQ-022 The block SHALL raise no stall for A-path hazards; forwarding elsewhere covers them.

Reset
REQ-023 While rst_i is high at a clock edge, the pending bits, starve_cnt, rd_we_o, rd_addr_o and rd_val_o SHALL clear to 0.
REQ-024 a_ready_o and b_ready_o SHALL be 0 while rst_i is high, so that no request completes during reset.
REQ-025 A B request pending when reset occurs SHALL be dropped by the block; the requester SHALL re-present it or abandon it after reset.

Structure
REQ-026 `GPR_NUM, `GPR_WIDTH and `GPR_ADDR_SPACE SHALL come from the shared defines file, and the default STARVE_MAX SHALL also be defined there.
REQ-027 The scoreboard SHALL be a sub-module, rf_scoreboard, with set port, clear port, two read ports and a read port for rd.
REQ-028 The arbiter, starvation counter and output register SHALL reside in rf_wb_arbiter.

Verification
REQ-029 A writes x5=0xDEADBEEF while B is idle -> a_ready_o=1 the same cycle; the next cycle rd_we_o=1, rd_addr_o=5, rd_val_o=0xDEADBEEF.
REQ-030 A and B are valid continuously with STARVE_MAX=3 -> A wins 3 cycles, B wins on the 4th, then A wins again; starve_cnt returns to 0 after B wins.
REQ-031 A long issue with rd=7 is followed by an issue with rs1=7 -> stall_o=1 until B completes on x7; stall_o=0 the cycle after that completion.
REQ-032 In one cycle a long issue with rd=9 is accepted and B completes on x9 -> bit 9 remains set.
REQ-033 B writes x0 -> b_ready_o=1; the next cycle rd_we_o=0; bit 0 is never set.
REQ-034 Reset is asserted while B is valid and bits 3 and 4 are set -> the pending vector reads 0, both readys are 0, and rd_we_o=0 on the next cycle.
